// File: rtl/btb_pkg.sv
// Shared types and helpers for the set-associative branch target buffer.
// Entry field widths follow the package-level geometry below.
package btb_pkg;

  localparam int BTB_SETS       = 32;
  localparam int BTB_WAYS       = 2;
  localparam int BTB_CTR_BITS   = 2;
  localparam int BTB_INDEX_BITS = $clog2(BTB_SETS);
  localparam int BTB_TAG_BITS   = 30 - BTB_INDEX_BITS;

  typedef logic [BTB_CTR_BITS-1:0] ctr_t;

  typedef struct packed {
    logic                    valid;
    logic [BTB_TAG_BITS-1:0] tag;
    logic [31:0]             target;
    ctr_t                    ctr;
  } btb_entry_t;

  // Freshly allocated entries start weakly taken so they redirect at once.
  localparam ctr_t CTR_WEAK_TAKEN = ctr_t'(1) << (BTB_CTR_BITS - 1);
  localparam ctr_t CTR_MAX        = '1;

  function automatic ctr_t sat_inc(input ctr_t c);
    return (c == CTR_MAX) ? c : c + ctr_t'(1);
  endfunction

  function automatic ctr_t sat_dec(input ctr_t c);
    return (c == '0) ? c : c - ctr_t'(1);
  endfunction

endpackage

// File: rtl/btb_plru.sv
// Tree pseudo-LRU state for one BTB set: WAYS-1 bits, each pointing at the
// colder half of its subtree. Optional flush clear under BTB_FLUSH_EN.
module btb_plru #(
  parameter int WAYS     = 2,
  parameter int WAY_BITS = (WAYS > 1) ? $clog2(WAYS) : 1
) (
  input  logic                clk,
  input  logic                reset,
`ifdef BTB_FLUSH_EN
  input  logic                clear,
`endif
  input  logic                touch_en,
  input  logic [WAY_BITS-1:0] touch_way,
  output logic [WAY_BITS-1:0] victim_way
);

  generate
    if (WAYS == 1) begin : g_single
      assign victim_way = '0;
      logic unused_single;
`ifdef BTB_FLUSH_EN
      assign unused_single = ^{clk, reset, clear, touch_en, touch_way};
`else
      assign unused_single = ^{clk, reset, touch_en, touch_way};
`endif
    end else begin : g_tree
      localparam int LEVELS = $clog2(WAYS);

      logic [WAYS-2:0] tree_reg;
      logic [WAYS-2:0] tree_next;

      // Heap layout: node n has children 2n+1 (lower ways) and 2n+2.
      function automatic logic [WAY_BITS-1:0] pick_victim(input logic [WAYS-2:0] t);
        logic [WAY_BITS-1:0] v;
        int node;
        v    = '0;
        node = 0;
        for (int l = 0; l < LEVELS; l++) begin
          v[LEVELS-1-l] = t[node];
          node = 2 * node + 1 + int'(t[node]);
        end
        return v;
      endfunction

      function automatic logic [WAYS-2:0] touch_tree(input logic [WAYS-2:0] t,
                                                      input logic [WAY_BITS-1:0] w);
        logic [WAYS-2:0] r;
        int node;
        r    = t;
        node = 0;
        for (int l = 0; l < LEVELS; l++) begin
          r[node] = ~w[LEVELS-1-l];
          node = 2 * node + 1 + int'(w[LEVELS-1-l]);
        end
        return r;
      endfunction

      assign victim_way = pick_victim(tree_reg);

      always_comb begin
        tree_next = tree_reg;
        if (touch_en) tree_next = touch_tree(tree_reg, touch_way);
      end

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          tree_reg <= '0;
        end
`ifdef BTB_FLUSH_EN
        else if (clear) begin
          tree_reg <= '0;
        end
`endif
        else begin
          tree_reg <= tree_next;
        end
      end
    end
  endgenerate

endmodule

// File: rtl/btb_set_assoc.sv
// Set-associative BTB: combinational lookup, registered update, per-set tree PLRU.
// Optional macro BTB_FLUSH_EN adds a flush port that invalidates the whole table.
module btb_set_assoc
  import btb_pkg::*;
#(
  parameter int SETS       = BTB_SETS,
  parameter int WAYS       = BTB_WAYS,
  parameter int CTR_BITS   = BTB_CTR_BITS,
  parameter int INDEX_BITS = $clog2(SETS),
  parameter int TAG_BITS   = 30 - INDEX_BITS
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] lookup_pc,
  output logic        btb_hit,
  output logic [31:0] predicted_target,
  input  logic        update_en,
  input  logic [31:0] update_pc,
  input  logic        update_taken,
  input  logic [31:0] update_target
`ifdef BTB_FLUSH_EN
  ,
  input  logic        flush
`endif
);

  localparam int WAY_BITS = (WAYS > 1) ? $clog2(WAYS) : 1;

  btb_entry_t table_reg [SETS][WAYS];

  logic [INDEX_BITS-1:0] lk_idx, up_idx;
  logic [TAG_BITS-1:0]   lk_tag, up_tag;

  assign lk_idx = lookup_pc[INDEX_BITS+1:2];
  assign lk_tag = lookup_pc[31:INDEX_BITS+2];
  assign up_idx = update_pc[INDEX_BITS+1:2];
  assign up_tag = update_pc[31:INDEX_BITS+2];

  logic unused_pc_bits;
  assign unused_pc_bits = ^{lookup_pc[1:0], update_pc[1:0]};

  logic [WAYS-1:0] lk_hit_vec;
  logic [WAYS-1:0] up_match_vec;
  logic [WAYS-1:0] up_free_vec;

  generate
    for (genvar gi = 0; gi < WAYS; gi++) begin : g_way
      assign lk_hit_vec[gi]   = table_reg[lk_idx][gi].valid
                              && (table_reg[lk_idx][gi].tag == lk_tag)
                              && table_reg[lk_idx][gi].ctr[CTR_BITS-1];
      assign up_match_vec[gi] = table_reg[up_idx][gi].valid
                              && (table_reg[up_idx][gi].tag == up_tag);
      assign up_free_vec[gi]  = !table_reg[up_idx][gi].valid;
    end
  endgenerate

  // Update keeps at most one matching way per set, so the OR-select is exact.
  always_comb begin
    btb_hit          = 1'b0;
    predicted_target = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (lk_hit_vec[w]) begin
        btb_hit          = 1'b1;
        predicted_target = table_reg[lk_idx][w].target;
      end
    end
  end

  logic [WAY_BITS-1:0] match_way, free_way, write_way;
  logic [WAY_BITS-1:0] victim_ways [SETS];
  logic                any_match, any_free, write_en, do_write;

  // Descending scan so the lowest-index way wins.
  always_comb begin
    match_way = '0;
    free_way  = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (up_match_vec[w]) match_way = WAY_BITS'(w);
      if (up_free_vec[w])  free_way  = WAY_BITS'(w);
    end
  end

  assign any_match = |up_match_vec;
  assign any_free  = |up_free_vec;
  assign write_en  = update_en && (any_match || update_taken);
  assign write_way = any_match ? match_way
                   : (any_free ? free_way : victim_ways[up_idx]);

`ifdef BTB_FLUSH_EN
  assign do_write = write_en && !flush;
`else
  assign do_write = write_en;
`endif

  btb_entry_t old_entry, new_entry;

  always_comb begin
    old_entry = table_reg[up_idx][write_way];
    new_entry = old_entry;
    if (any_match) begin
      new_entry.ctr = update_taken ? sat_inc(old_entry.ctr) : sat_dec(old_entry.ctr);
      if (update_taken) new_entry.target = update_target;
    end else begin
      new_entry.valid  = 1'b1;
      new_entry.tag    = up_tag;
      new_entry.target = update_target;
      new_entry.ctr    = CTR_WEAK_TAKEN;
    end
  end

  generate
    for (genvar gi = 0; gi < SETS; gi++) begin : g_set
      btb_plru #(
        .WAYS     (WAYS),
        .WAY_BITS (WAY_BITS)
      ) u_plru (
        .clk        (clk),
        .reset      (reset),
`ifdef BTB_FLUSH_EN
        .clear      (flush),
`endif
        .touch_en   (do_write && (up_idx == INDEX_BITS'(gi))),
        .touch_way  (write_way),
        .victim_way (victim_ways[gi])
      );
    end
  endgenerate

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int s = 0; s < SETS; s++) begin
        for (int w = 0; w < WAYS; w++) begin
          table_reg[s][w] <= '0;
        end
      end
    end
`ifdef BTB_FLUSH_EN
    else if (flush) begin
      for (int s = 0; s < SETS; s++) begin
        for (int w = 0; w < WAYS; w++) begin
          table_reg[s][w].valid <= 1'b0;
        end
      end
    end
`endif
    else if (do_write) begin
      table_reg[up_idx][write_way] <= new_entry;
    end
  end

endmodule

// File: doc/btb_set_assoc.md
Name: btb_set_assoc

Overview:
- Set-associative Branch Target Buffer with per-entry saturating direction counters and tree pseudo-LRU replacement.
- Next generation of the direct-mapped 1-bit BTB; sits in the IF stage.
- Combinational lookup on the fetch PC; registered update from the EX/branch-resolve stage.
- Redirects fetch only when an entry matches and its counter predicts taken.

Parameters:
- SETS, 32, number of sets; power of 2, >= 2.
- WAYS, 2, associativity; power of 2, 1..8.
- CTR_BITS, 2, saturating counter width; >= 1 (1 reproduces the old 1-bit behaviour).
- INDEX_BITS, $clog2(SETS), derived; set index = pc[INDEX_BITS+1:2].
- TAG_BITS, 30-INDEX_BITS, derived; tag = pc[31:INDEX_BITS+2].

Ports:
- clk  in  1  core clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- lookup_pc  in  32  fetch PC.
- btb_hit  out  1  valid tag match AND counter MSB = 1.
- predicted_target  out  32  target of the matching way; 0 when btb_hit = 0.
- update_en  in  1  resolved control-flow instruction this cycle.
- update_pc  in  32  PC of the resolved instruction.
- update_taken  in  1  actual outcome.
- update_target  in  32  actual target; meaningful only when update_taken = 1.
- flush  in  1  present only with BTB_FLUSH_EN.

Behaviour:
- Reset (reset = 0, async): all valid bits, tags, targets, counters and PLRU bits cleared.
  - Outputs go to btb_hit = 0 and predicted_target = 0 immediately.
- Lookup is zero-latency combinational.
  - Match = valid && tag equal. At most one way matches (invariant maintained by update).
  - Hit requires match && ctr[CTR_BITS-1] = 1. A matched entry with MSB = 0 gives btb_hit = 0, target 0.
  - Lookup never modifies state, including PLRU.
- Update, when update_en = 1, writes on the rising edge after it is presented.
  - Matching way present, update_taken = 1: ctr = sat_inc(ctr); target <= update_target.
  - Matching way present, update_taken = 0: ctr = sat_dec(ctr); target kept; entry stays valid.
  - No match, update_taken = 1: allocate victim. victim = lowest-index invalid way, else the PLRU way.
    - Written as valid = 1, tag, target, ctr = 2^(CTR_BITS-1) (weakly taken).
  - No match, update_taken = 0: no allocation, no state change.
  - PLRU of the update set is touched (marks the way most-recently-used) on every update that writes an entry. Untouched otherwise.
- Counter saturation: never wraps. Max (all ones) + taken stays max; 0 + not-taken stays 0.
- PLRU is a binary tree of WAYS-1 bits per set; WAYS = 1 means no PLRU storage, victim = way 0.
- Lookup and update to the same set in the same cycle: lookup sees pre-update contents; no bypass.
- update_en = 0: state holds.
- X on update_pc/update_target is ignored while update_en = 0.
- Reset asserted mid-update: reset wins; the table is fully cleared.

Optional Feature:
- Macro: BTB_FLUSH_EN.
- Defined:
  - flush port exists.
  - flush = 1 clears every valid bit and all PLRU bits on the next rising edge. Tags, targets and counters are don't-care.
  - flush has priority over a same-cycle update, which is dropped.
  - btb_hit = 0 from the cycle after the flush edge.
- Undefined: no flush port and no flush logic; the table is cleared only by reset.

Decomposition:
- Package btb_pkg:
  - btb_entry_t packed struct: valid, tag, target, ctr, sized from package-level parameters.
  - Counter constants CTR_WEAK_TAKEN and CTR_MAX.
  - Functions sat_inc and sat_dec.
- Sub-module btb_plru (one instance per set, or a generate-based array).
  - Inputs: touch_en, touch_way.
  - Output: victim_way.
  - Holds the WAYS-1 tree bits and resets them async on reset.

Test Plan (defaults SETS=32, WAYS=2, CTR_BITS=2):
1. Release reset -> lookup_pc = 0x0000_0100 gives btb_hit = 0, predicted_target = 0.
2. Allocate and repeat:
   - Update pc 0x100, taken, target 0x200 -> next cycle lookup 0x100 gives hit = 1, target 0x200.
   - Second taken update -> ctr = 11.
3. Hysteresis from ctr = 11:
   - Two not-taken updates to 0x100 -> ctr = 01, hit = 0, entry still valid.
   - One taken update -> ctr = 10, hit = 1 with the same target.
4. Associativity: pcs 0x100, 0x1100 and 0x2100 share set 0.
   - Taken updates to 0x100 then 0x1100 -> both hit.
   - Then 0x2100 taken -> evicts 0x100 (the PLRU way): 0x100 misses; 0x1100 and 0x2100 hit.
5. Not-taken update to 0x3000 with no match -> no allocation; the set's contents and PLRU are unchanged.
6. Async reset mid-run: assert reset between clock edges with entries valid.
   - btb_hit drops immediately.
   - After release, every previously valid pc misses.
   - With BTB_FLUSH_EN: flush plus a same-cycle update -> all miss, and the update is not written.
